// File: rtl/iq_trace_capture.sv
// Multi-channel IQ trace buffer: circular capture with decimation and a
// pre/post trigger window, drained oldest-first as a valid/ready word stream.
module iq_trace_capture #(
    parameter  int NCH   = 4,
    parameter  int IQW   = 16,
    parameter  int DEPTH = 256,
    parameter  int DECW  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rn,
    input  logic               en,
    input  logic               InValid,
    input  logic [NCH*IQW-1:0] In_I_,
    input  logic [NCH*IQW-1:0] In_Q_,
    input  logic               Arm,
    input  logic               TrigIn,
    input  logic [AW:0]        PostCnt,
    input  logic [DECW-1:0]    Decim,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [IQW-1:0]     Out_I_,
    output logic [IQW-1:0]     Out_Q_,
    output logic [CW-1:0]      OutCh,
    output logic               OutLast,
    output logic               Busy,
    output logic               Done
);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DRAIN} state_t;

    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE     = (AW+1)'(1);
    localparam logic [CW-1:0] CH_LAST = CW'(NCH-1);

    state_t                 state;
    logic [AW-1:0]          wr_ptr;
    logic [AW:0]            fill;
    logic [AW:0]            post_cnt;
    logic [AW:0]            post_lim;
    logic [AW:0]            rd_off;
    logic [CW-1:0]          rd_ch;
    logic [DECW-1:0]        dec_cnt;
    logic [DECW-1:0]        dec_lim;
    logic                   v1;
    logic                   last1;
    logic [CW-1:0]          ch1;
    logic [2*NCH*IQW-1:0]   mem [DEPTH];
    logic [2*NCH*IQW-1:0]   rdata;

    logic            beat;
    logic            capt;
    logic            trig;
    logic            we;
    logic            adv;
    logic            issue;
    logic            re;
    logic            fire_last;
    logic [AW-1:0]   rd_addr;
    logic [AW:0]     post_eff;
    logic [AW:0]     post_nxt;
    logic [DECW-1:0] dec_nxt;

    assign beat      = InValid && en;
    assign capt      = (state == ARMED || state == POST) && !Arm;
    assign trig      = capt && beat && TrigIn && (state == ARMED);
    assign we        = !rn && capt && beat && (trig || dec_cnt == '0);
    assign adv       = !OutValid || OutReady;
    assign issue     = (state == DRAIN) && (rd_off != fill);
    assign re        = issue && adv;
    assign fire_last = OutValid && OutReady && OutLast;
    assign rd_addr   = wr_ptr - fill[AW-1:0] + rd_off[AW-1:0];
    assign post_nxt  = post_cnt + 1'b1;
    assign dec_nxt   = (dec_cnt == dec_lim) ? '0 : dec_cnt + 1'b1;
    assign Busy      = (state != IDLE);

    always_comb begin
        post_eff = PostCnt;
        if (PostCnt == '0)
            post_eff = ONE;
        else if (PostCnt > FULL)
            post_eff = FULL;
    end

    // Entry = all channels of one beat, Q above I.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_ptr] <= {In_Q_, In_I_};
        if (re)
            rdata <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rn) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            fill     <= '0;
            post_cnt <= '0;
            post_lim <= ONE;
            rd_off   <= '0;
            rd_ch    <= '0;
            dec_cnt  <= '0;
            dec_lim  <= '0;
            v1       <= 1'b0;
            last1    <= 1'b0;
            ch1      <= '0;
            OutValid <= 1'b0;
            Out_I_   <= '0;
            Out_Q_   <= '0;
            OutCh    <= '0;
            OutLast  <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state != DRAIN) begin
                rd_off <= '0;
                rd_ch  <= '0;
                v1     <= 1'b0;
                if (Arm) begin
                    state    <= ARMED;
                    fill     <= '0;
                    dec_cnt  <= '0;
                    dec_lim  <= Decim;
                    post_lim <= post_eff;
                    post_cnt <= '0;
                end else if (state != IDLE && beat) begin
                    if (we) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (fill != FULL)
                            fill <= fill + 1'b1;
                    end
                    if (trig) begin
                        // Trigger beat counts as decimation phase 0.
                        dec_cnt  <= (dec_lim == '0) ? '0 : DECW'(1);
                        post_cnt <= ONE;
                        state    <= (post_lim <= ONE) ? DRAIN : POST;
                    end else begin
                        dec_cnt <= dec_nxt;
                        if (state == POST && we) begin
                            post_cnt <= post_nxt;
                            if (post_nxt == post_lim)
                                state <= DRAIN;
                        end
                    end
                end
            end else begin
                // Whole read pipeline advances together, so stalls never bubble.
                if (adv) begin
                    v1 <= issue;
                    if (issue) begin
                        ch1   <= rd_ch;
                        last1 <= (rd_off == fill - 1'b1) && (rd_ch == CH_LAST);
                        if (rd_ch == CH_LAST) begin
                            rd_ch  <= '0;
                            rd_off <= rd_off + 1'b1;
                        end else begin
                            rd_ch <= rd_ch + 1'b1;
                        end
                    end
                    OutValid <= v1;
                    OutCh    <= ch1;
                    OutLast  <= v1 && last1;
                    Out_I_   <= rdata[ch1*IQW +: IQW];
                    Out_Q_   <= rdata[NCH*IQW + ch1*IQW +: IQW];
                end
                if (fire_last) begin
                    state    <= IDLE;
                    Done     <= 1'b1;
                    OutValid <= 1'b0;
                    OutLast  <= 1'b0;
                    v1       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_trace_capture.sv
// Directed bench for iq_trace_capture: scoreboard of expected words,
// filled as beats are driven and drained against the output stream.
module tb_iq_trace_capture;

    localparam int NCH   = 2;
    localparam int IQW   = 16;
    localparam int DEPTH = 8;
    localparam int DECW  = 8;

    logic               clk = 1'b0;
    logic               rn;
    logic               en;
    logic               InValid;
    logic [NCH*IQW-1:0] In_I_;
    logic [NCH*IQW-1:0] In_Q_;
    logic               Arm;
    logic               TrigIn;
    logic [3:0]         PostCnt;
    logic [DECW-1:0]    Decim;
    logic               OutValid;
    logic               OutReady;
    logic [IQW-1:0]     Out_I_;
    logic [IQW-1:0]     Out_Q_;
    logic               OutCh;
    logic               OutLast;
    logic               Busy;
    logic               Done;

    iq_trace_capture #(
        .NCH(NCH), .IQW(IQW), .DEPTH(DEPTH), .DECW(DECW)
    ) dut (
        .clk(clk), .rn(rn), .en(en), .InValid(InValid),
        .In_I_(In_I_), .In_Q_(In_Q_), .Arm(Arm), .TrigIn(TrigIn),
        .PostCnt(PostCnt), .Decim(Decim), .OutValid(OutValid),
        .OutReady(OutReady), .Out_I_(Out_I_), .Out_Q_(Out_Q_),
        .OutCh(OutCh), .OutLast(OutLast), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ch;
        logic        last;
        logic [15:0] i;
        logic [15:0] q;
    } word_t;

    word_t sb[$];
    int    checks = 0;
    int    fails  = 0;
    logic [3:0] pat = 4'b1001;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry(input int n);
        for (int c = 0; c < NCH; c++) begin
            word_t w;
            int    v;
            v      = n + 100 * c;
            w.ch   = 1'(c);
            w.last = 1'b0;
            w.i    = 16'(v);
            w.q    = 16'(-v);
            sb.push_back(w);
        end
    endtask

    task automatic mark_last();
        word_t w;
        w      = sb.pop_back();
        w.last = 1'b1;
        sb.push_back(w);
    endtask

    task automatic arm(input int pc, input int dc);
        @(negedge clk);
        InValid = 1'b0;
        TrigIn  = 1'b0;
        Arm     = 1'b1;
        PostCnt = 4'(pc);
        Decim   = DECW'(dc);
        @(negedge clk);
        Arm = 1'b0;
        chk("busy_after_arm", 64'(Busy), 64'(1));
    endtask

    task automatic beat(input int n, input bit t, input bit e);
        @(negedge clk);
        Arm     = 1'b0;
        en      = e;
        InValid = 1'b1;
        TrigIn  = t;
        In_I_   = {16'(n + 100), 16'(n)};
        In_Q_   = {16'(-(n + 100)), 16'(-n)};
    endtask

    // mode 0: ready always; mode 1: ready pattern 1,0,0,1.
    task automatic drain(input int mode, input int stop_after, input int exp_lat);
        word_t held, obsw, e;
        bit    pend = 0, first = 1, fin = 0, stop = 0;
        int    got = 0, lat = 0;
        for (int cyc = 0; cyc < 300 && !fin && !stop; cyc++) begin
            @(negedge clk);
            InValid = 1'b0;
            TrigIn  = 1'b0;
            obsw = {OutCh, OutLast, Out_I_, Out_Q_};
            if (pend) begin
                chk("stall_hold", 64'({OutValid, obsw}), 64'({1'b1, held}));
                pend = 0;
            end
            OutReady = (mode == 0) ? 1'b1 : pat[cyc % 4];
            if (OutValid) begin
                if (first) begin
                    if (exp_lat >= 0)
                        chk("first_valid_latency", 64'(lat), 64'(exp_lat));
                    first = 0;
                end
                if (!OutReady) begin
                    held = obsw;
                    pend = 1;
                end else begin
                    chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("word", 64'(obsw), 64'(e));
                        got++;
                        if (OutLast) fin = 1;
                        if (got == stop_after) stop = 1;
                    end
                end
            end else if (first) begin
                lat++;
            end
        end
        chk("drain_reached_end", 64'(fin || stop), 64'(1));
        if (fin) begin
            @(negedge clk);
            chk("done_pulse", 64'({Done, Busy, OutValid}), 64'(3'b100));
            @(negedge clk);
            chk("done_clear", 64'({Done, OutValid}), 64'(0));
            chk("sb_empty", 64'(sb.size()), 64'(0));
        end
    endtask

    initial begin
        rn       = 1'b1;
        en       = 1'b1;
        InValid  = 1'b0;
        In_I_    = '0;
        In_Q_    = '0;
        Arm      = 1'b0;
        TrigIn   = 1'b0;
        PostCnt  = '0;
        Decim    = '0;
        OutReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({OutValid, Busy, Done, OutLast}), 64'(0));
        rn = 1'b0;

        // basic window: 3 pre, trigger + 2 post
        arm(3, 0);
        for (int n = 0; n < 6; n++) begin
            beat(n, n == 3, 1'b1);
            push_entry(n);
        end
        mark_last();
        drain(0, 0, 2);

        // wraparound, buffer saturated
        arm(2, 0);
        for (int n = 0; n < 20; n++) begin
            beat(n, n == 18, 1'b1);
            if (n >= 12) push_entry(n);
        end
        mark_last();
        drain(0, 0, 2);

        // decimation by 3 with trigger re-phasing
        arm(2, 2);
        for (int n = 0; n < 11; n++) begin
            beat(n, n == 7, 1'b1);
            if (n == 0 || n == 3 || n == 6 || n == 7 || n == 10) push_entry(n);
        end
        mark_last();
        drain(0, 0, 2);

        // backpressure
        arm(3, 0);
        for (int n = 0; n < 6; n++) begin
            beat(n, n == 3, 1'b1);
            push_entry(n);
        end
        mark_last();
        drain(1, 0, -1);

        // enable gating: beats 2,3 dropped, their trigger ignored
        arm(3, 0);
        for (int n = 0; n < 8; n++) begin
            bit e;
            e = !(n == 2 || n == 3);
            beat(n, n == 3 || n == 5, e);
            if (e) push_entry(n);
        end
        mark_last();
        drain(0, 0, 2);

        // re-arm during POST discards the earlier window
        arm(3, 0);
        for (int n = 0; n < 4; n++) beat(n, n == 2, 1'b1);
        arm(3, 0);
        for (int n = 20; n < 25; n++) begin
            beat(n, n == 22, 1'b1);
            push_entry(n);
        end
        mark_last();
        drain(0, 0, 2);

        // reset mid-drain
        arm(3, 0);
        for (int n = 0; n < 6; n++) begin
            beat(n, n == 3, 1'b1);
            push_entry(n);
        end
        mark_last();
        drain(0, 3, 2);
        @(negedge clk);
        rn = 1'b1;
        @(negedge clk);
        rn = 1'b0;
        chk("reset_mid_drain", 64'({OutValid, Busy, Done}), 64'(0));
        sb.delete();

        // PostCnt=0 behaves as 1: trigger beat closes the window
        arm(0, 0);
        beat(50, 1'b0, 1'b1);
        push_entry(50);
        beat(51, 1'b1, 1'b1);
        push_entry(51);
        mark_last();
        drain(0, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
